// File: rtl/arb_types.sv
// Shared types for the I/D-cache physical-memory arbiter.
package arb_types;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } arb_state_t;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } grant_t;

endpackage

// File: rtl/arb_priority.sv
// Combinational winner selection between the I-cache and D-cache requests.
// ARB_ROUND_ROBIN_EN: alternate on conflicts using the last-grant bit; otherwise D wins conflicts.
module arb_priority
    import arb_types::*;
(
`ifdef ARB_ROUND_ROBIN_EN
    input  grant_t last_grant,
`endif
    input  logic   req_i,
    input  logic   req_d,
    output logic   any_req,
    output grant_t winner
);

    always_comb begin
        any_req = req_i | req_d;
`ifdef ARB_ROUND_ROBIN_EN
        if (req_i && req_d) begin
            winner = (last_grant == GRANT_D) ? GRANT_I : GRANT_D;
        end else begin
            winner = req_d ? GRANT_D : GRANT_I;
        end
`else
        winner = req_d ? GRANT_D : GRANT_I;
`endif
    end

endmodule

// File: rtl/cache_arbiter.sv
// Shares the single cacheline-adaptor port between the I-cache and D-cache.
// ARB_ROUND_ROBIN_EN selects round-robin conflict resolution instead of fixed D priority.
module cache_arbiter
    import arb_types::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t state_q, state_d;
    logic       any_req;
    grant_t     winner;

`ifdef ARB_ROUND_ROBIN_EN
    grant_t last_grant_q, last_grant_d;
`endif

    arb_priority u_prio (
`ifdef ARB_ROUND_ROBIN_EN
        .last_grant (last_grant_q),
`endif
        .req_i      (i_pmem_read),
        .req_d      (d_pmem_read | d_pmem_write),
        .any_req    (any_req),
        .winner     (winner)
    );

    // Read data is broadcast; only the resp strobe qualifies it per requester.
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;
    assign pmem_wdata   = d_pmem_wdata;

    always_comb begin
        state_d      = state_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = d_pmem_address;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d      = (winner == GRANT_D) ? SERVE_D : SERVE_I;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d = winner;
`endif
                end
            end
            SERVE_I: begin
                pmem_read    = i_pmem_read;
                pmem_address = i_pmem_address;
                i_pmem_resp  = pmem_resp;
                if (pmem_resp) state_d = IDLE;
            end
            SERVE_D: begin
                pmem_read    = d_pmem_read;
                pmem_write   = d_pmem_write;
                d_pmem_resp  = pmem_resp;
                if (pmem_resp) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Reset value makes the I-cache the favoured requester on the first conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GRANT_D;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    a_i_hold: assert property (@(posedge clk) disable iff (rst)
        (state_q == SERVE_I) |-> i_pmem_read)
        else $error("i_pmem_read dropped while granted");

    a_d_hold: assert property (@(posedge clk) disable iff (rst)
        (state_q == SERVE_D) |-> (d_pmem_read | d_pmem_write))
        else $error("D-cache request dropped while granted");

    a_d_rw: assert property (@(posedge clk) disable iff (rst)
        !(d_pmem_read && d_pmem_write))
        else $error("d_pmem_read and d_pmem_write asserted together");

endmodule
